// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
// Optional build macro DIV_ZERO_CHECK_EN sends a zero divisor straight to DONE and flags div_by_zero.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is taken on a rising edge only while state is IDLE or DONE;
    // done is a one-cycle pulse with results valid, and results hold until the next done.
    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           last;
    logic           start_to_done;

    // acc starts as the dividend and fills with quotient bits from the LSB as dividend bits leave the MSB.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r_shift;
    logic             ge;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_CHECK_EN
    assign start_to_done = (divisor == '0);
`else
    assign start_to_done = 1'b0;
`endif

    // The partial remainder is always below the divisor after an iteration, so WIDTH stored bits suffice.
    assign r_shift = {r, acc[WIDTH-1]};
    assign ge      = (r_shift >= {1'b0, dsr});
    assign r_next  = ge ? (r_shift[WIDTH-1:0] - dsr) : r_shift[WIDTH-1:0];
    assign q_next  = {acc[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = start_to_done ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            dsr       <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            acc <= dividend;
            dsr <= divisor;
            r   <= '0;
            cnt <= '0;
            if (start_to_done) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == RUN) begin
            acc <= q_next;
            r   <= r_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                quotient  <= q_next;
                remainder <= r_next;
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbz <= 1'b0;
        end else if (accept) begin
            dbz <= start_to_done;
        end
    end

    assign div_by_zero = dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against a cycle-level arithmetic model.
// Follows the DIV_ZERO_CHECK_EN build macro when it is defined.
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_pass = 0;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (b == 0) return {{WIDTH{1'b1}}, a};
        return {a / b, a % b};
    endfunction

    // Model: counts edges since the accepting edge; results land WIDTH edges later.
    logic [2*WIDTH-1:0] exp_q[$];
    bit               m_active = 1'b0;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_q = '0;
    logic [WIDTH-1:0] m_r = '0;
    logic             m_dbz = 1'b0;
    bit               m_can_accept;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_q      = '0;
            m_r      = '0;
            m_dbz    = 1'b0;
            exp_q.delete();
        end else begin
            m_can_accept = !m_active || (m_cnt == WIDTH);
            if (m_active) begin
                m_cnt++;
                if (m_cnt > WIDTH) m_active = 1'b0;
            end
            if (m_active && m_cnt == WIDTH && exp_q.size() > 0) begin
                {m_q, m_r} = exp_q.pop_front();
            end
            if (start && m_can_accept) begin
                m_active = 1'b1;
                m_cnt    = 0;
`ifdef DIV_ZERO_CHECK_EN
                m_dbz = (divisor == 0);
                if (divisor == 0) begin
                    m_cnt = WIDTH;
                    m_q   = '1;
                    m_r   = dividend;
                end else begin
                    exp_q.push_back(ref_div(dividend, divisor));
                end
`else
                exp_q.push_back(ref_div(dividend, divisor));
`endif
            end
        end
    end

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_active && m_cnt < WIDTH));
        check("done", 32'(done), 32'(m_active && m_cnt == WIDTH));
        check("quotient", 32'(quotient), 32'(m_q));
        check("remainder", 32'(remainder), 32'(m_r));
        check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    // Returns in the done cycle; lat is the cycle count after the accepting edge.
    task automatic wait_done(input bit noise, output int lat, output int bc);
        lat = 1;
        bc  = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            start = 1'b0;
            if (done) return;
            if (busy) begin
                bc++;
                if (noise) begin
                    start    = 1'($urandom_range(0, 1));
                    dividend = WIDTH'($urandom);
                    divisor  = WIDTH'($urandom);
                end
            end
            tick();
            lat++;
        end
        check("done_timeout", 32'(1), 32'(0));
    endtask

    task automatic run_lit(input string name, input int a, input int b,
                           input int eq, input int er, input int elat, input int edbz);
        int lat;
        int bc;
        launch(WIDTH'(a), WIDTH'(b));
        wait_done(1'b0, lat, bc);
        check({name, "_q"}, 32'(quotient), 32'(eq));
        check({name, "_r"}, 32'(remainder), 32'(er));
        check({name, "_lat"}, 32'(lat), 32'(elat));
        check({name, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        if (a == 200 && b == 7) check("busy_cycles_200_7", 32'(bc), 32'(WIDTH));
        tick();
    endtask

    initial begin
        int lat;
        int bc;
        bit saw;
        int a;
        int b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_q", 32'(quotient), 32'(0));
        check("rst_r", 32'(remainder), 32'(0));
        check("rst_dbz", 32'(div_by_zero), 32'(0));
        rst_n = 1'b1;
        tick();

        run_lit("d200_7", 200, 7, 28, 4, 9, 0);
        run_lit("d255_1", 255, 1, 255, 0, 9, 0);
        run_lit("d5_9", 5, 9, 0, 5, 9, 0);
        run_lit("d0_3", 0, 3, 0, 0, 9, 0);
        run_lit("d255_255", 255, 255, 1, 0, 9, 0);
`ifdef DIV_ZERO_CHECK_EN
        run_lit("d100_0", 100, 0, 255, 100, 1, 1);
`else
        run_lit("d100_0", 100, 0, 255, 100, 9, 0);
`endif

        // start during RUN is ignored; start in the done cycle is taken
        launch(8'd200, 8'd7);
        tick();
        tick();
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        tick();
        start = 1'b0;
        wait_done(1'b0, lat, bc);
        check("b2b_first_q", 32'(quotient), 32'(28));
        check("b2b_first_r", 32'(remainder), 32'(4));
        launch(8'd50, 8'd3);
        check("b2b_busy_rise", 32'(busy), 32'(1));
        check("b2b_held_q", 32'(quotient), 32'(28));
        wait_done(1'b0, lat, bc);
        check("b2b_second_q", 32'(quotient), 32'(16));
        check("b2b_second_r", 32'(remainder), 32'(2));
        check("b2b_second_lat", 32'(lat), 32'(9));
        tick();

        // reset in the middle of an operation
        launch(8'd200, 8'd7);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_q", 32'(quotient), 32'(0));
        check("midrst_r", 32'(remainder), 32'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) saw = 1'b1;
            tick();
        end
        check("midrst_no_done", 32'(saw), 32'(0));
        run_lit("d9_2", 9, 2, 4, 1, 9, 0);

        // randomized operations, mixed gaps and back-to-back starts
        for (int n = 0; n < 1500; n++) begin
            a = $urandom_range(0, (1 << WIDTH) - 1);
            case ($urandom_range(0, 9))
                0:       b = 0;
                1:       b = 1;
                2:       b = (1 << WIDTH) - 1;
                3:       b = $urandom_range(1, 15);
                default: b = $urandom_range(0, (1 << WIDTH) - 1);
            endcase
            launch(WIDTH'(a), WIDTH'(b));
            wait_done(1'b1, lat, bc);
`ifdef DIV_ZERO_CHECK_EN
            check("rand_lat", 32'(lat), 32'((b == 0) ? 1 : WIDTH + 1));
`else
            check("rand_lat", 32'(lat), 32'(WIDTH + 1));
`endif
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
